// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: run/flag inputs, fetched bus byte, and datapath control strobes of the CPU sequencer.
interface cpu_sequencer_if;
    logic       run;
    logic [7:0] bus_in;
    logic       carry_in;
    logic       zero_in;
    logic       pc_oe;
    logic       pc_cnt;
    logic       pc_down;
    logic       pc_set;
    logic       mar_ld;
    logic       ram_oe;
    logic       ram_ld;
    logic       ir_oe;
    logic       a_ld;
    logic       a_oe;
    logic       b_ld;
    logic       alu_oe;
    logic       alu_sub;
    logic       flags_ld;
    logic       out_ld;
    logic       halted;
    logic [2:0] tstate;

    modport master (
        input  run, bus_in, carry_in, zero_in,
        output pc_oe, pc_cnt, pc_down, pc_set, mar_ld, ram_oe, ram_ld, ir_oe,
               a_ld, a_oe, b_ld, alu_oe, alu_sub, flags_ld, out_ld, halted, tstate
    );

    modport slave (
        output run, bus_in, carry_in, zero_in,
        input  pc_oe, pc_cnt, pc_down, pc_set, mar_ld, ram_oe, ram_ld, ir_oe,
               a_ld, a_oe, b_ld, alu_oe, alu_sub, flags_ld, out_ld, halted, tstate
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: T-state microcode sequencer for the 8-bit bus CPU.
// Fetches into IR, decodes (tstate, opcode, flags) into control strobes, drives the operand nibble.
module cpu_sequencer #(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus,
    output logic [7:0]      bus_out
);
    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] op;
    logic       en, ir_ld, undef_op, halt_op, mem_op, alu_op;

    assign op       = ir_q[7:4];
    assign en       = bus.run && !reset;
    assign undef_op = op inside {[4'hA:4'hD]};
    assign halt_op  = op == 4'hF || (HALT_ON_UNDEF && undef_op);
    assign mem_op   = op inside {4'h1, 4'h2, 4'h3, 4'h4};
    assign alu_op   = op inside {4'h2, 4'h3};

    // With en low every strobe stays at its default, so nothing in the datapath moves.
    always_comb begin
        state_d      = state_q;
        ir_ld        = 1'b0;
        bus.pc_oe    = 1'b0;
        bus.pc_cnt   = 1'b0;
        bus.pc_down  = 1'b0;
        bus.pc_set   = 1'b0;
        bus.mar_ld   = 1'b0;
        bus.ram_oe   = 1'b0;
        bus.ram_ld   = 1'b0;
        bus.ir_oe    = 1'b0;
        bus.a_ld     = 1'b0;
        bus.a_oe     = 1'b0;
        bus.b_ld     = 1'b0;
        bus.alu_oe   = 1'b0;
        bus.alu_sub  = 1'b0;
        bus.flags_ld = 1'b0;
        bus.out_ld   = 1'b0;
        if (en) begin
            case (state_q)
                T0: begin
                    bus.pc_oe  = 1'b1;
                    bus.mar_ld = 1'b1;
                    state_d    = T1;
                end
                T1: begin
                    bus.ram_oe = 1'b1;
                    ir_ld      = 1'b1;
                    bus.pc_cnt = 1'b1;
                    state_d    = T2;
                end
                T2: begin
                    state_d = halt_op ? HALT : mem_op ? T3 : T0;
                    case (op)
                        4'h1, 4'h2, 4'h3, 4'h4: begin
                            bus.ir_oe  = 1'b1;
                            bus.mar_ld = 1'b1;
                        end
                        4'h5: begin
                            bus.ir_oe = 1'b1;
                            bus.a_ld  = 1'b1;
                        end
                        4'h6: begin
                            bus.ir_oe  = 1'b1;
                            bus.pc_set = 1'b1;
                        end
                        4'h7: begin
                            bus.ir_oe  = bus.carry_in;
                            bus.pc_set = bus.carry_in;
                        end
                        4'h8: begin
                            bus.ir_oe  = bus.zero_in;
                            bus.pc_set = bus.zero_in;
                        end
                        4'h9: begin
                            bus.pc_cnt  = 1'b1;
                            bus.pc_down = 1'b1;
                        end
                        4'hE: begin
                            bus.a_oe   = 1'b1;
                            bus.out_ld = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    state_d = alu_op ? T4 : T0;
                    case (op)
                        4'h1: begin
                            bus.ram_oe = 1'b1;
                            bus.a_ld   = 1'b1;
                        end
                        4'h2, 4'h3: begin
                            bus.ram_oe = 1'b1;
                            bus.b_ld   = 1'b1;
                        end
                        4'h4: begin
                            bus.a_oe   = 1'b1;
                            bus.ram_ld = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    bus.alu_oe   = 1'b1;
                    bus.a_ld     = 1'b1;
                    bus.flags_ld = 1'b1;
                    bus.alu_sub  = op == 4'h3;
                    state_d      = T0;
                end
                default: state_d = HALT;
            endcase
        end
    end

    assign ir_d = ir_ld ? bus.bus_in : ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.halted = state_q == HALT;
    assign bus.tstate = state_q;
    assign bus_out    = bus.ir_oe ? {4'h0, ir_q[3:0]} : 8'bz;
endmodule
